// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - opcode/REGIMM constants and decode helpers for the ID branch controller
package branch_resolve_ctrl_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    function automatic logic is_regimm_branch(input logic [4:0] rt);
        return (rt == RT_BLTZ) || (rt == RT_BGEZ) || (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
    endfunction

    function automatic logic is_branch_op(input logic [5:0] op, input logic [4:0] rt);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
               ((op == OP_REGIMM) && is_regimm_branch(rt));
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4, input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch condition equations, shared between ID and a future EX resolver
module branch_cond
    import branch_resolve_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  op,
    input  logic [4:0]  rt,
    output logic        take
);

    logic a_zero;
    logic regimm;

    always_comb begin
        a_zero = (a == 32'd0);
        regimm = (op == OP_REGIMM);
        take   = ((op == OP_BEQ)  && (a == b)) ||
                 ((op == OP_BNE)  && (a != b)) ||
                 ((op == OP_BGTZ) && !a[31] && !a_zero) ||
                 ((op == OP_BLEZ) && (a[31] || a_zero)) ||
                 (regimm && ((rt == RT_BGEZ) || (rt == RT_BGEZAL)) && !a[31]) ||
                 (regimm && ((rt == RT_BLTZ) || (rt == RT_BLTZAL)) && a[31]);
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - decode-stage branch resolve: operand stall, redirect handshake,
// delay-slot tracking, AL link write and saturating taken/not-taken statistics
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rt,
    input  logic [15:0]      id_imm,
    input  logic [31:0]      id_pc_plus4,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             if_ack,
    output logic             stall_d,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             link_we,
    output logic [31:0]      link_data,
    output logic             ds_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_OPND = 2'd1,
        ST_REDIRECT  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             ds_flag_q, ds_flag_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             link_we_q, link_we_d;
    logic [31:0]      link_data_q, link_data_d;
    logic             ds_err_q, ds_err_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] nt_cnt_q, nt_cnt_d;

    logic   is_br, real_br, ds_hit, needs_rt, opnd_ok;
    logic   redirect_blocked, accept, take, is_al;
    state_e free_next;

    branch_cond u_cond (
        .a    (rs_data),
        .b    (rt_data),
        .op   (id_op),
        .rt   (id_rt),
        .take (take)
    );

    always_comb begin
        is_br    = id_valid && is_branch_op(id_op, id_rt);
        // A branch sitting in a delay slot is never evaluated, so it neither waits nor stalls.
        real_br  = is_br && !ds_flag_q;
        ds_hit   = is_br && ds_flag_q;
        needs_rt = (id_op == OP_BEQ) || (id_op == OP_BNE);
        opnd_ok  = rs_ready && (rt_ready || !needs_rt);
        is_al    = (id_op == OP_REGIMM) && ((id_rt == RT_BLTZAL) || (id_rt == RT_BGEZAL));

        redirect_blocked = (state_q == ST_REDIRECT) && !if_ack;
        accept           = real_br && opnd_ok && !redirect_blocked;
        stall_d          = (real_br && !opnd_ok) || (real_br && redirect_blocked);

        if (accept) begin
            free_next = take ? ST_REDIRECT : ST_IDLE;
        end else if (real_br) begin
            free_next = ST_WAIT_OPND;
        end else begin
            free_next = ST_IDLE;
        end
    end

    always_comb begin
        state_d        = state_q;
        ds_flag_d      = ds_flag_q;
        redirect_pc_d  = redirect_pc_q;
        link_we_d      = 1'b0;
        link_data_d    = link_data_q;
        ds_err_d       = ds_hit;
        taken_cnt_d    = taken_cnt_q;
        nt_cnt_d       = nt_cnt_q;

        unique case (state_q)
            ST_IDLE, ST_WAIT_OPND: state_d = free_next;
            ST_REDIRECT:           state_d = if_ack ? free_next : ST_REDIRECT;
            default:               state_d = ST_IDLE;
        endcase

        redirect_valid_d = (state_d == ST_REDIRECT);

        if (accept) begin
            ds_flag_d = 1'b1;
            if (take) begin
                redirect_pc_d = branch_target(id_pc_plus4, id_imm);
                if (taken_cnt_q != {CNT_W{1'b1}}) taken_cnt_d = taken_cnt_q + CNT_ONE;
            end else begin
                if (nt_cnt_q != {CNT_W{1'b1}}) nt_cnt_d = nt_cnt_q + CNT_ONE;
            end
            if (is_al) begin
                link_we_d   = 1'b1;
                link_data_d = id_pc_plus4 + 32'd4;
            end
        end else if (id_valid && !stall_d) begin
            ds_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            ds_flag_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            link_we_q        <= 1'b0;
            link_data_q      <= 32'd0;
            ds_err_q         <= 1'b0;
            taken_cnt_q      <= '0;
            nt_cnt_q         <= '0;
        end else begin
            state_q          <= state_d;
            ds_flag_q        <= ds_flag_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            link_we_q        <= link_we_d;
            link_data_q      <= link_data_d;
            ds_err_q         <= ds_err_d;
            taken_cnt_q      <= taken_cnt_d;
            nt_cnt_q         <= nt_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign link_we        = link_we_q;
    assign link_data      = link_data_q;
    assign ds_err         = ds_err_q;
    assign taken_cnt      = taken_cnt_q;
    assign nt_cnt         = nt_cnt_q;

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Decode-stage branch controller for the MIPS pipeline.
- Recognises conditional branches in ID and stalls ID until the source operands are forwarded-ready.
- Evaluates the branch condition, then holds a PC redirect request until fetch acknowledges it.
- Tracks the architectural delay slot, emits the link write for the AL variants, and keeps saturating taken/not-taken statistics.

Parameters:
- CNT_W, 16, width of the taken and not-taken statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  6  opcode field
- id_rt  in  5  rt field (selects the REGIMM variant)
- id_imm  in  16  branch offset
- id_pc_plus4  in  32  PC of the branch + 4
- rs_data  in  32  forwarded rs value
- rt_data  in  32  forwarded rt value
- rs_ready  in  1  rs_data is final this cycle
- rt_ready  in  1  rt_data is final this cycle
- if_ack  in  1  fetch has consumed the redirect
- stall_d  out  1  hold the IF/ID register
- redirect_valid  out  1  redirect request pending
- redirect_pc  out  32  branch target
- link_we  out  1  write r31
- link_data  out  32  return address
- ds_err  out  1  branch found in a delay slot
- taken_cnt  out  CNT_W  count of taken branches
- nt_cnt  out  CNT_W  count of not-taken branches

Behaviour:
- Reset is asynchronous: state=IDLE; ds_flag, redirect_valid, redirect_pc, link_we, link_data, ds_err, taken_cnt and nt_cnt all clear to 0.
- Branch decode (is_br):
  - id_valid & op in {BEQ, BNE, BLEZ, BGTZ}, or
  - op=REGIMM & rt in {BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001}.
  - Any other REGIMM rt is not a branch.
- Operand needs: rs is needed for every branch; rt is needed for BEQ/BNE only. opnd_ok = rs_ready & (rt_ready | !needs_rt).
- Condition, each term gated by its own opcode:
  - BEQ: a==b
  - BNE: a!=b
  - BGTZ: !a[31] & a!=0
  - BLEZ: a[31] | a==0
  - BGEZ/BGEZAL: !a[31]
  - BLTZ/BLTZAL: a[31]
- Target = id_pc_plus4 + {sext(id_imm),2'b00}, modulo 2^32.
- States:
  - IDLE:
    - is_br & !opnd_ok -> WAIT_OPND.
    - is_br & opnd_ok -> accept this cycle.
  - WAIT_OPND:
    - Wait is unbounded.
    - opnd_ok -> accept.
    - id_valid drops (upstream flush) -> IDLE, no side effects.
  - REDIRECT:
    - redirect_valid=1 and redirect_pc stable.
    - if_ack -> clear redirect_valid, go to IDLE (same edge).
- stall_d (combinational) = (is_br & !opnd_ok) | (state==REDIRECT & is_br & !if_ack).
- Accept (one cycle):
  - Taken: at the next edge redirect_valid=1, redirect_pc=target, state=REDIRECT, taken_cnt++.
  - Not taken: nt_cnt++, state=IDLE.
  - AL variants: link_we pulses 1 cycle after accept with link_data=id_pc_plus4+4, whether or not the branch is taken.
  - ds_flag is set.
- Delay slot:
  - ds_flag clears on the next id_valid non-stalled instruction (the slot).
  - The slot is never flushed, and it passes freely while a REDIRECT is pending.
- Branch in a delay slot (is_br while ds_flag=1): ds_err pulses 1 cycle. The branch is treated as not taken, with no counter update, no link and no redirect. ds_flag clears.
- Counters saturate at all-ones and never wrap.
- A reset asserted in any state aborts immediately; the pending redirect is lost.

Decomposition:
- Opcode and REGIMM rt constants come from the shared defines header (BEQ, BNE, BGTZ, BLEZ, REGIMM_INST, plus new BLTZ/BGEZ/BLTZAL/BGEZAL rt codes).
- The state encoding (IDLE=0, WAIT_OPND=1, REDIRECT=2) is local.
- One combinational sub-module, branch_cond(a, b, op, rt -> take), holds the condition equations and is shared with any future EX-stage resolver.

Test Plan:
- BEQ, rs=rt=5, both ready, pc+4=0x100, imm=0x0004 -> no stall; next cycle redirect_valid=1, redirect_pc=0x110; hold it 3 cycles with if_ack=0, then if_ack=1 -> redirect_valid=0; taken_cnt=1.
- BNE, rt_ready=0 for 2 cycles -> stall_d=1 for exactly 2 cycles; rt=rs -> not taken, nt_cnt=1, no redirect.
- BLEZ on a=0x00000001 -> not taken; a=0 -> taken; a=0x80000000 -> taken. BGTZ on a=0 -> not taken.
- BLTZAL, a=0x7FFFFFFF, pc+4=0x200 -> not taken, link_we=1 for one cycle, link_data=0x204.
- BGEZ immediately followed by BEQ in the slot -> ds_err=1 for one cycle, second branch ignored, taken_cnt increments once.
- CNT_W=2, 5 taken branches -> taken_cnt=3. Assert rst during WAIT_OPND -> all outputs 0 asynchronously, state IDLE.
